// File: rtl/seq_isqrt.sv
// seq_isqrt: restoring digit-by-digit integer square root, one root bit per clock.
// Optional SEQ_ISQRT_ROUND_EN rounds the posted root to nearest (saturating).
module seq_isqrt #(
  parameter int XW    = 32,
  parameter int FRACW = 0,
  localparam int QW   = XW/2 + FRACW,
  localparam int CW   = $clog2(QW+1),
  localparam int SW   = XW + 2*FRACW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [XW-1:0] xin,
  output logic [QW-1:0] sqrt,
  output logic [QW:0]   rem,
  output logic          busy,
  output logic          ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sh_q, sh_d;
  logic [QW-1:0] q_q, q_d;
  logic [QW:0]   r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] sqrt_q, sqrt_d;
  logic [QW:0]   rem_q, rem_d;
  logic          rdy_q, rdy_d;

  logic [QW+1:0] r_sh;
  logic [QW+1:0] t_try;
  logic [QW-1:0] q_fin;

  // r never exceeds 2q, so its top bit is zero whenever it is shifted
  assign r_sh  = {r_q[QW-1:0], sh_q[SW-1 -: 2]};
  assign t_try = {q_q, 2'b01};

`ifdef SEQ_ISQRT_ROUND_EN
  // round to nearest: r > q means sqrt is past q+0.5; clamp at all-ones
  always_comb begin
    q_fin = q_q;
    if ((r_q > {1'b0, q_q}) && !(&q_q))
      q_fin = q_q + QW'(1);
  end
`else
  assign q_fin = q_q;
`endif

  // state and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      sqrt_q  <= '0;
      rem_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      sqrt_q  <= sqrt_d;
      rem_q   <= rem_d;
      rdy_q   <= rdy_d;
    end
  end

  // next-state: accept, iterate one restoring step, post result
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    sqrt_d  = sqrt_q;
    rem_d   = rem_q;
    rdy_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          sh_d    = SW'(xin) << (2*FRACW);
          q_d     = '0;
          r_d     = '0;
          cnt_d   = CW'(QW);
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          sh_d = sh_q << 2;
          if (r_sh >= t_try) begin
            r_d = (QW+1)'(r_sh - t_try);
            q_d = {q_q[QW-2:0], 1'b1};
          end else begin
            r_d = (QW+1)'(r_sh);
            q_d = {q_q[QW-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1))
            state_d = DONE;
        end
      end
      DONE: begin
        sqrt_d  = q_fin;
        rem_d   = r_q;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sqrt  = sqrt_q;
  assign rem   = rem_q;
  assign busy  = (state_q == RUN);
  assign ready = rdy_q;

endmodule

// File: tb/tb_seq_isqrt.sv
// tb_seq_isqrt: scoreboard bench for seq_isqrt, default and FRACW=4 instances.
// Expected results come from a binary-search integer square root model.
module tb_seq_isqrt;

  localparam int QW  = 16;
  localparam int FQW = 20;

  typedef struct {
    longint unsigned s;
    longint unsigned r;
    int unsigned     due;
  } exp_t;

  logic          clock;
  logic          reset;
  logic          start, stop;
  logic [31:0]   xin;
  logic [QW-1:0] sqrt;
  logic [QW:0]   rem;
  logic          busy, ready;

  logic           fstart, fstop;
  logic [31:0]    fxin;
  logic [FQW-1:0] fsqrt;
  logic [FQW:0]   frem;
  logic           fbusy, fready;

  exp_t        q[$];
  exp_t        fq[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned cyc    = 0;
  int          run_len = 0;
  int          last_len = 0;
  logic        prev_busy = 1'b0;

  seq_isqrt #(.XW(32), .FRACW(0)) u_dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .xin(xin), .sqrt(sqrt), .rem(rem), .busy(busy), .ready(ready)
  );

  seq_isqrt #(.XW(32), .FRACW(4)) u_frac (
    .clock(clock), .reset(reset), .start(fstart), .stop(fstop),
    .xin(fxin), .sqrt(fsqrt), .rem(frem), .busy(fbusy), .ready(fready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  function automatic void ref_model(input longint unsigned x,
                                    input int frac, input int qw,
                                    output longint unsigned s,
                                    output longint unsigned r);
    longint unsigned big, lo, hi, mid, top;
    big = x << (2*frac);
    top = (64'd1 << qw) - 64'd1;
    lo  = 0;
    hi  = top;
    while (lo < hi) begin
      mid = lo + (hi - lo + 64'd1) / 64'd2;
      if (mid * mid <= big) lo = mid;
      else hi = mid - 64'd1;
    end
    r = big - lo * lo;
    s = lo;
`ifdef SEQ_ISQRT_ROUND_EN
    if (r > lo && lo != top) s = lo + 64'd1;
`endif
  endfunction

  task automatic check(input string nm, input longint unsigned act,
                       input longint unsigned want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  // main-instance monitor: pop on every ready pulse
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (busy) run_len++;
    else if (prev_busy) begin
      last_len = run_len;
      run_len  = 0;
    end
    prev_busy = busy;
    if (ready) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_ready: got ready=1 at cycle %0d, expected none", cyc);
      end else begin
        e = q.pop_front();
        check("sqrt", 64'(sqrt), e.s);
        check("rem", 64'(rem), e.r);
        check("latency", 64'(cyc), 64'(e.due));
        check("busy_len", 64'(last_len), 64'(QW));
      end
    end
  end

  // fractional-instance monitor
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (fready) begin
      if (fq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL frac_spurious_ready: got ready=1 at cycle %0d, expected none", cyc);
      end else begin
        e = fq.pop_front();
        check("frac_sqrt", 64'(fsqrt), e.s);
        check("frac_rem", 64'(frem), e.r);
        check("frac_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  // called at a negedge with the DUT idle
  task automatic issue(input logic [31:0] x);
    exp_t e;
    ref_model(64'(x), 0, QW, e.s, e.r);
    e.due = cyc + QW + 2;
    q.push_back(e);
    start = 1'b1;
    xin   = x;
    @(negedge clock);
    start = 1'b0;
    xin   = $urandom;
  endtask

  task automatic fissue(input logic [31:0] x);
    exp_t e;
    ref_model(64'(x), 4, FQW, e.s, e.r);
    e.due = cyc + FQW + 2;
    fq.push_back(e);
    fstart = 1'b1;
    fxin   = x;
    @(negedge clock);
    fstart = 1'b0;
    fxin   = $urandom;
  endtask

  task automatic wait_ready(input bit frac);
    for (int i = 0; i < 60; i++) begin
      if (frac ? fready : ready) return;
      @(negedge clock);
    end
    n_chk++;
    n_fail++;
    $display("FAIL ready_timeout: got no ready within 60 cycles, expected one");
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    xin    = '0;
    fstart = 1'b0;
    fstop  = 1'b0;
    fxin   = '0;
    #3;
    check("rst_sqrt", 64'(sqrt), 0);
    check("rst_rem", 64'(rem), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_ready", 64'(ready), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    issue(32'd0);          wait_ready(0);
    issue(32'd123);        wait_ready(0);
    issue(32'd456);        wait_ready(0);
    issue(32'hFFFF_FFFF);  wait_ready(0);
    issue(32'd120);        wait_ready(0);

    // abort mid-run: prior result 11/2 must survive
    issue(32'd123);        wait_ready(0);
    start = 1'b1;
    xin   = 32'd456;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check("stop_busy", 64'(busy), 0);
    repeat (25) @(negedge clock);
    check("stop_hold_sqrt", 64'(sqrt), 11);
    check("stop_hold_rem", 64'(rem), 2);

    // stop in IDLE blocks start
    start = 1'b1;
    stop  = 1'b1;
    xin   = 32'd77;
    @(negedge clock);
    start = 1'b0;
    stop  = 1'b0;
    check("stop_idle_busy", 64'(busy), 0);
    repeat (20) @(negedge clock);

    // start during RUN is ignored
    issue(32'd1000);
    repeat (3) @(negedge clock);
    start = 1'b1;
    xin   = 32'd5;
    @(negedge clock);
    start = 1'b0;
    wait_ready(0);

    // stop during DONE is ignored
    issue(32'd99999);
    repeat (QW) @(negedge clock);
    check("done_busy", 64'(busy), 0);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    wait_ready(0);

    // randomized, back-to-back
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) issue(32'($urandom_range(0, 1100)));
      else issue($urandom);
      wait_ready(0);
    end

    // asynchronous reset mid-run
    @(negedge clock);
    start = 1'b1;
    xin   = 32'd500;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 0);
    check("arst_ready", 64'(ready), 0);
    check("arst_sqrt", 64'(sqrt), 0);
    check("arst_rem", 64'(rem), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    issue(32'd144);
    wait_ready(0);

    // fractional instance
    @(negedge clock);
    fissue(32'd2);
    wait_ready(1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      fissue($urandom);
      wait_ready(1);
    end

    repeat (5) @(negedge clock);
    check("queue_empty", 64'(q.size()), 0);
    check("frac_queue_empty", 64'(fq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
